// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types, opcodes and per-state control decode for the multicycle MIPS controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {PC_SRC_ALU = 2'b00, PC_SRC_ALUOUT = 2'b01, PC_SRC_JUMP = 2'b10} pc_src_t;
  typedef enum logic [1:0] {CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10} trap_cause_t;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_RS      = 1'b1;
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  // Moore part of the outputs; the FETCH pc_write/ir_write strobes are added by the top.
  function automatic ctrl_t ctrl_decode(state_t s);
    ctrl_t c;
    c = '0;
    c.alu_src_a = SRC_A_PC;
    c.alu_src_b = SRC_B_RT;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRC_B_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS;
        c.alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRC_A_RS;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_WB_I:   c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = SRC_A_RS;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
      end
      S_TRAP:   c.trap = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle controller and its datapath
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, trap, trap_cause
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, trap, trap_cause
  );
endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive not-ready memory cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  // count_q holds waits already seen, so the MAX_WAIT-th stalled cycle sees MAX_WAIT-1.
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = inc && (count_q == LAST);
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FSM sequencing fetch/decode/execute/mem/writeback with memory-wait and illegal-op traps
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus
);
  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;
  ctrl_t       ctrl_q, ctrl_d, ctrl_out;
  logic        in_mem_state, wait_expired, fetch_done;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_mem_state || bus.mem_ready),
    .inc     (in_mem_state && !bus.mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = (state_q == S_FETCH)  ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDIU:     state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
    ctrl_d = ctrl_decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Everything is forced low while reset is held, including the cycle it first drops.
  assign ctrl_out   = rst_n ? ctrl_q : '0;
  assign fetch_done = rst_n && (state_q == S_FETCH) && bus.mem_ready;

  assign bus.pc_write      = ctrl_out.pc_write || fetch_done;
  assign bus.ir_write      = fetch_done;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.trap          = ctrl_out.trap;
  assign bus.trap_cause    = rst_n ? cause_q : CAUSE_NONE;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed plus randomized instruction traces checked against an expected-trace model
module tb_multicycle_control;
  localparam int MAX_WAIT = 15;

  typedef logic [18:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected outputs for one named instruction step, straight from the output table.
  function automatic vec_t expect_for(string st, bit rdy, logic [1:0] cause);
    logic pw, pwc, iod, mr, mw, iw, m2r, rd, rw, sa, tr;
    logic [1:0] sb, op, ps, tc;
    {pw, pwc, iod, mr, mw, iw, m2r, rd, rw, sa, tr} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00; tc = 2'b00;
    if (st == "fetch") begin
      mr = 1'b1; sb = 2'b01; pw = rdy; iw = rdy;
    end else if (st == "decode") begin
      sb = 2'b11;
    end else if (st == "mem_addr") begin
      sa = 1'b1; sb = 2'b10;
    end else if (st == "mem_rd") begin
      mr = 1'b1; iod = 1'b1;
    end else if (st == "mem_wb") begin
      rw = 1'b1; m2r = 1'b1;
    end else if (st == "mem_wr") begin
      mw = 1'b1; iod = 1'b1;
    end else if (st == "exec_r") begin
      sa = 1'b1; op = 2'b10;
    end else if (st == "wb_r") begin
      rw = 1'b1; rd = 1'b1;
    end else if (st == "exec_i") begin
      sa = 1'b1; sb = 2'b10;
    end else if (st == "wb_i") begin
      rw = 1'b1;
    end else if (st == "branch") begin
      sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01;
    end else if (st == "jump") begin
      pw = 1'b1; ps = 2'b10;
    end else if (st == "trap") begin
      tr = 1'b1; tc = cause;
    end
    return {pw, pwc, iod, mr, mw, iw, m2r, rd, rw, sa, sb, op, ps, tr, tc};
  endfunction

  function automatic vec_t observed();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.trap, bus.trap_cause};
  endfunction

  task automatic chk(string tag, vec_t e);
    vec_t o;
    o = observed();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic step(string st, logic [5:0] opc, bit rdy, logic [1:0] cause);
    @(negedge clk);
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    #1;
    chk(st, expect_for(st, rdy, cause));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'($urandom);
    #1;
    chk("reset_low_first", '0);
    @(negedge clk);
    #1;
    chk("reset_low_held", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle", '0);
  endtask

  // A memory step lasts waits+1 cycles; the MAX_WAIT-th consecutive stall traps instead.
  task automatic mem_phase(string st, logic [5:0] opc, int waits, output bit timed_out);
    bit rdy;
    timed_out = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      rdy = (i == waits);
      step(st, (st == "fetch") ? 6'($urandom) : opc, rdy, 2'b00);
      if (!rdy && i == MAX_WAIT - 1) begin
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  task automatic trap_then_reset(logic [1:0] cause);
    repeat (3) step("trap", 6'($urandom), 1'($urandom), cause);
    do_reset();
  endtask

  task automatic run_instr(logic [5:0] opc, int wf, int wm);
    bit to;
    mem_phase("fetch", opc, wf, to);
    if (to) begin
      trap_then_reset(2'b10);
      return;
    end
    step("decode", opc, 1'($urandom), 2'b00);
    case (opc)
      6'b000000: begin
        step("exec_r", opc, 1'($urandom), 2'b00);
        step("wb_r", opc, 1'($urandom), 2'b00);
      end
      6'b100011: begin
        step("mem_addr", opc, 1'($urandom), 2'b00);
        mem_phase("mem_rd", opc, wm, to);
        if (to) trap_then_reset(2'b10);
        else step("mem_wb", opc, 1'($urandom), 2'b00);
      end
      6'b101011: begin
        step("mem_addr", opc, 1'($urandom), 2'b00);
        mem_phase("mem_wr", opc, wm, to);
        if (to) trap_then_reset(2'b10);
      end
      6'b000100: step("branch", opc, 1'($urandom), 2'b00);
      6'b001001: begin
        step("exec_i", opc, 1'($urandom), 2'b00);
        step("wb_i", opc, 1'($urandom), 2'b00);
      end
      6'b000010: step("jump", opc, 1'($urandom), 2'b00);
      default:   trap_then_reset(2'b01);
    endcase
  endtask

  function automatic bit is_legal(logic [5:0] opc);
    return opc == 6'b000000 || opc == 6'b100011 || opc == 6'b101011 ||
           opc == 6'b000100 || opc == 6'b001001 || opc == 6'b000010;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    logic [5:0] opc;
    int r;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001001, 6'b000010};
    r = $urandom_range(0, 13);
    if (r < 12) return legal[r / 2];
    opc = 6'($urandom);
    while (is_legal(opc)) opc = 6'($urandom);
    return opc;
  endfunction

  function automatic int pick_waits();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return r % 4;
    if (r < 18) return MAX_WAIT - 1;
    if (r == 18) return MAX_WAIT;
    return 0;
  endfunction

  initial begin
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    do_reset();

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b101011, 1, 0);
    run_instr(6'b001001, 2, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, MAX_WAIT, 0);
    run_instr(6'b100011, MAX_WAIT - 1, MAX_WAIT);
    run_instr(6'b101011, 0, MAX_WAIT - 1);

    step("fetch", 6'b000000, 1'b1, 2'b00);
    step("decode", 6'b101011, 1'b1, 2'b00);
    step("mem_addr", 6'b101011, 1'b0, 2'b00);
    step("mem_wr", 6'b101011, 1'b0, 2'b00);
    do_reset();

    repeat (200) run_instr(pick_op(), pick_waits(), pick_waits());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
